// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//
// Arbitrates between two requesters that want to modify the 16x8 LED frame
// buffer and turns each accepted operation into masked column writes. Port 0
// is the UART command decoder and port 1 is the animation/scroll engine.
// Grants alternate round-robin when both ports ask in the same cycle. No new
// work starts while the panel scan holds the buffer (fb_hold).
//
// Operations (reqN_op):
//   00 SET   : set one pixel bit   (bit index = reqN_data[2:0])
//   01 CLR   : clear one pixel bit (bit index = reqN_data[2:0])
//   10 WRCOL : overwrite a whole column with reqN_data
//   11 CLEAR : blank the whole buffer, one column per unheld cycle
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   fb_hold                 scan busy; blocks accepts and clear steps
//   reqN_valid/op/col/data  request from port N (held stable until accepted)
//   reqN_ready              combinational accept for port N
//   fb_we                   one-cycle write strobe per column write
//   fb_col                  column being written
//   fb_mask                 bits of the column that the write modifies
//   fb_wdata                new values for the masked bits
//   busy                    CLEAR sequence in progress
//
// The buffer applies: new = (old & ~fb_mask) | (fb_wdata & fb_mask).

module fb_write_arbiter #(
  parameter int COLS  = 16,
  parameter int ROWS  = 8,
  parameter int COL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fb_hold,

  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [COL_W-1:0] req0_col,
  input  logic [ROWS-1:0]  req0_data,
  output logic             req0_ready,

  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [COL_W-1:0] req1_col,
  input  logic [ROWS-1:0]  req1_data,
  output logic             req1_ready,

  output logic             fb_we,
  output logic [COL_W-1:0] fb_col,
  output logic [ROWS-1:0]  fb_mask,
  output logic [ROWS-1:0]  fb_wdata,
  output logic             busy
);

  localparam int IDX_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    OP_SET   = 2'b00,
    OP_CLR   = 2'b01,
    OP_WRCOL = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  // Sequencer state
  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [COL_W-1:0] clr_cnt_q, clr_cnt_d;

  // Registered write produced by a single-cycle op, plus the held
  // column/mask/data that the outputs show when nothing is written.
  logic             wr_we_q, wr_we_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROWS-1:0]  mask_q, mask_d;
  logic [ROWS-1:0]  wdata_q, wdata_d;

  // Arbitration and selected request
  logic             can_accept;
  logic             grant0, grant1;
  logic             accept;
  op_e              sel_op;
  logic [COL_W-1:0] sel_col;
  logic [ROWS-1:0]  sel_data;
  logic [ROWS-1:0]  bit_mask;
  logic             clear_write;

  // Round-robin grant: a lone valid port always wins; on a tie the port
  // that did not win last time goes first. Nothing is accepted while a
  // CLEAR runs or the scan holds the buffer, so at most one ready is high.
  always_comb begin
    can_accept = (state_q == ST_IDLE) && !fb_hold;
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    grant0     = req0_valid && !grant1;
    req0_ready = can_accept && grant0;
    req1_ready = can_accept && grant1;
    accept     = req0_ready || req1_ready;
    sel_op     = op_e'(grant1 ? req1_op : req0_op);
    sel_col    = grant1 ? req1_col : req0_col;
    sel_data   = grant1 ? req1_data : req0_data;
    bit_mask   = ROWS'(1) << sel_data[IDX_W-1:0];
  end

  // Next-state logic. Single-cycle ops load the output registers so the
  // write appears the cycle after the accept and never gets cancelled by a
  // later fb_hold. CLEAR writes are issued in the cycle itself so that a
  // held cycle shows no strobe and freezes the column counter.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    clr_cnt_d    = clr_cnt_q;
    wr_we_d      = 1'b0;
    col_d        = col_q;
    mask_d       = mask_q;
    wdata_d      = wdata_q;
    clear_write  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          last_grant_d = grant1;
          case (sel_op)
            OP_SET: begin
              wr_we_d = 1'b1;
              col_d   = sel_col;
              mask_d  = bit_mask;
              wdata_d = {ROWS{1'b1}};
            end
            OP_CLR: begin
              wr_we_d = 1'b1;
              col_d   = sel_col;
              mask_d  = bit_mask;
              wdata_d = {ROWS{1'b0}};
            end
            OP_WRCOL: begin
              wr_we_d = 1'b1;
              col_d   = sel_col;
              mask_d  = {ROWS{1'b1}};
              wdata_d = sel_data;
            end
            OP_CLEAR: begin
              state_d   = ST_CLEAR;
              clr_cnt_d = '0;
            end
          endcase
        end
      end

      ST_CLEAR: begin
        if (!fb_hold) begin
          clear_write = 1'b1;
          col_d       = clr_cnt_q;
          mask_d      = {ROWS{1'b1}};
          wdata_d     = {ROWS{1'b0}};
          if (clr_cnt_q == COL_W'(COLS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            clr_cnt_d = clr_cnt_q + COL_W'(1);
          end
        end
      end
    endcase
  end

  // State and output registers. last_grant resets to port 1 so that
  // port 0 wins the first tie after reset; a reset during CLEAR simply
  // drops the remaining columns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      clr_cnt_q    <= '0;
      wr_we_q      <= 1'b0;
      col_q        <= '0;
      mask_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_we_q      <= wr_we_d;
      col_q        <= col_d;
      mask_q       <= mask_d;
      wdata_q      <= wdata_d;
    end
  end

  // Output mux: a clear step drives the bus directly, otherwise the
  // registered values are shown (held from the last write).
  always_comb begin
    fb_we    = wr_we_q || clear_write;
    fb_col   = clear_write ? clr_cnt_q : col_q;
    fb_mask  = clear_write ? {ROWS{1'b1}} : mask_q;
    fb_wdata = clear_write ? {ROWS{1'b0}} : wdata_q;
    busy     = (state_q == ST_CLEAR);
  end

endmodule
